// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock, MSB first).
// Optional macro BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits with 4'hF.
module bin_to_bcd_seq #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd_out,
    output logic             ovf
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIN_W-1:0] sr_q, sr_d;
    logic [15:0]      acc_q, acc_d;
    logic [15:0]      bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic             big_q, big_d;
    logic [15:0]      acc_adj, acc_shift;
    logic             big_in;
    logic             last_bit;

    function automatic logic [15:0] add3(input logic [15:0] a);
        logic [15:0] r;
        r = a;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [15:0] fmt(input logic [15:0] acc, input logic big);
        logic [15:0] r;
        r = big ? 16'h9999 : acc;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        // Blank from the top down; stop at the first non-zero digit, never touch ones.
        if (r[15:12] == 4'd0) begin
            r[15:12] = 4'hF;
            if (r[11:8] == 4'd0) begin
                r[11:8] = 4'hF;
                if (r[7:4] == 4'd0) r[7:4] = 4'hF;
            end
        end
`endif
        return r;
    endfunction

    // Values above 9999 overflow the 4-digit accumulator, so flag them at capture.
    assign big_in    = (32'(bin_in) > 32'd9999);
    assign acc_adj   = add3(acc_q);
    assign acc_shift = {acc_adj[14:0], sr_q[BIN_W-1]};
    assign last_bit  = (cnt_q == CNT_W'(BIN_W - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        big_d   = big_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sr_d    = bin_in;
                    acc_d   = '0;
                    big_d   = big_in;
                end
            end
            SHIFT: begin
                acc_d = acc_shift;
                sr_d  = {sr_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                    bcd_d   = fmt(acc_shift, big_q);
                    ovf_d   = big_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            big_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            big_q   <= big_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq with a result scoreboard checked on each done pulse.
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 14;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy;
    logic             done;
    logic [15:0]      bcd_out;
    logic             ovf;

    bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          edge_n;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        int x;
        logic [15:0] r;
        x = (v > 9999) ? 9999 : v;
        r = {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
`ifdef BCD_LEADING_ZERO_BLANK_EN
        if (x < 1000) r[15:12] = 4'hF;
        if (x < 100)  r[11:8]  = 4'hF;
        if (x < 10)   r[7:4]   = 4'hF;
`endif
        return r;
    endfunction

    function automatic exp_t mk(input int v, input int edge_n);
        exp_t e;
        e.bcd    = ref_bcd(v);
        e.ovf    = (v > 9999);
        e.edge_n = edge_n;
        return e;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest outstanding request.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (sb.size() == 0) chk("spurious_done", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                chk("latency", 32'(cyc), 32'(e.edge_n));
            end
        end
    end

    task automatic start_conv(input int v);
        logic [31:0] vv;
        vv = v;
        @(negedge clk);
        for (int i = 0; i < 40 && busy !== 1'b0; i++) @(negedge clk);
        start  = 1'b1;
        bin_in = vv[BIN_W-1:0];
        @(posedge clk);
        #1;
        sb.push_back(mk(v, cyc + BIN_W));
        chk("accept_busy", 32'(busy), 32'd1);
        @(negedge clk);
        start  = 1'b0;
        bin_in = BIN_W'($urandom_range(0, 16383));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int v;
        rst = 1'b0; start = 1'b0; bin_in = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        start_conv(0);     drain();
        // Stray start mid-conversion must be ignored.
        start_conv(1234);
        repeat (4) @(negedge clk);
        start = 1'b1; bin_in = BIN_W'(5555);
        @(negedge clk);
        start = 1'b0;
        drain();
        start_conv(9999);  drain();
        start_conv(7);     drain();
        start_conv(10000); drain();
        start_conv(16383); drain();

        // Start pulsed only during the DONE cycle is dropped.
        start_conv(555);
        for (int i = 0; i < 30 && done !== 1'b1; i++) @(negedge clk);
        chk("done_seen", 32'(done), 32'd1);
        start = 1'b1; bin_in = BIN_W'(3333);
        @(negedge clk);
        start = 1'b0;
        chk("done_start_ignored", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("still_idle", 32'(busy), 32'd0);
        drain();

        // Start held high with bin_in changing every cycle.
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 48; k++) begin
            v = $urandom_range(0, 16383);
            bin_in = BIN_W'(v);
            @(posedge clk);
            #1;
            if (k % 16 == 0) sb.push_back(mk(v, cyc + BIN_W));
            chk("b2b_busy", 32'(busy), 32'((k % 16) != 15));
            @(negedge clk);
        end
        start = 1'b0;
        drain();

        // Reset aborts a conversion in flight.
        start_conv(4321);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        sb.delete();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bcd", 32'(bcd_out), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 32'(bcd_out), 32'd0);
        start_conv(42);    drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
